// File: rtl/apb_slave_regs.sv
// APB slave with an 8-word register map (R0..R6 RW, 0x1C RO ID); APB_SLAVE_WRCNT_EN turns 0x18 into a RO count of successful writes.
// Latency: PREADY rises WAIT_CYCLES+1 cycles after the first PENABLE=1 cycle; PRDATA/PSLVERR are valid with it.
// Backpressure: PREADY is held low for WAIT_CYCLES ACCESS cycles; dropping PSEL aborts the transfer with no side effects.
module apb_slave_regs #(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [31:0] ID_VALUE    = 32'h4150_4253
) (
  input  logic        pclk_i,
  input  logic        preset_i,
  input  logic        psel_i,
  input  logic        penable_i,
  input  logic        pwrite_i,
  input  logic [31:0] paddr_i,
  input  logic [31:0] pwdata_i,
  output logic [31:0] prdata_o,
  output logic        pready_o,
  output logic        pslverr_o
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        wr_q, wr_d;
  logic [31:0] prdata_q, prdata_d;
  logic        pready_q, pready_d;
  logic        pslverr_q, pslverr_d;
  logic [31:0] regs_q [6];
  logic [31:0] regs_d [6];
`ifdef APB_SLAVE_WRCNT_EN
  logic [31:0] wrcnt_q, wrcnt_d;
`else
  logic [31:0] r6_q, r6_d;
`endif

  // With zero wait states the transfer completes straight out of SETUP,
  // so the live bus is used instead of the captured copy.
  logic        xfer_from_bus;
  logic [31:0] xfer_addr;
  logic [31:0] xfer_wdata;
  logic        xfer_wr;
  logic [2:0]  widx;
  logic        ro_hit;
  logic        xfer_err;
  logic        commit;
  logic [31:0] rdata;

  assign xfer_from_bus = (state_q == SETUP);
  assign xfer_addr     = xfer_from_bus ? paddr_i  : addr_q;
  assign xfer_wdata    = xfer_from_bus ? pwdata_i : wdata_q;
  assign xfer_wr       = xfer_from_bus ? pwrite_i : wr_q;
  assign widx          = xfer_addr[4:2];

`ifdef APB_SLAVE_WRCNT_EN
  assign ro_hit = (widx == 3'd7) || (widx == 3'd6);
`else
  assign ro_hit = (widx == 3'd7);
`endif

  assign xfer_err = (xfer_addr[1:0] != 2'b00) || (xfer_addr > 32'h0000_001C) ||
                    (xfer_wr && ro_hit);

  always_comb begin
    rdata = ID_VALUE;
    case (widx)
`ifdef APB_SLAVE_WRCNT_EN
      3'd6:    rdata = wrcnt_q;
`else
      3'd6:    rdata = r6_q;
`endif
      3'd7:    rdata = ID_VALUE;
      default: rdata = regs_q[widx];
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wr_d      = wr_q;
    prdata_d  = prdata_q;
    pready_d  = 1'b0;
    pslverr_d = pslverr_q;
    regs_d    = regs_q;
`ifdef APB_SLAVE_WRCNT_EN
    wrcnt_d   = wrcnt_q;
`else
    r6_d      = r6_q;
`endif
    commit    = 1'b0;

    case (state_q)
      IDLE: begin
        if (psel_i && !penable_i) begin
          state_d   = SETUP;
          pslverr_d = 1'b0;
        end
      end
      SETUP: begin
        if (!psel_i) begin
          state_d = IDLE;
        end else if (penable_i) begin
          addr_d  = paddr_i;
          wdata_d = pwdata_i;
          wr_d    = pwrite_i;
          cnt_d   = 4'(WAIT_CYCLES);
          if (WAIT_CYCLES == 0) begin
            state_d = DONE;
            commit  = 1'b1;
          end else begin
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (!psel_i) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q <= 4'd1) begin
            state_d = DONE;
            commit  = 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (commit) begin
      pready_d  = 1'b1;
      pslverr_d = xfer_err;
      if (!xfer_err) begin
        if (xfer_wr) begin
          if (widx == 3'd6) begin
`ifndef APB_SLAVE_WRCNT_EN
            r6_d = xfer_wdata;
`endif
          end else begin
            regs_d[widx] = xfer_wdata;
          end
`ifdef APB_SLAVE_WRCNT_EN
          wrcnt_d = wrcnt_q + 32'd1;
`endif
        end else begin
          prdata_d = rdata;
        end
      end
    end
  end

  always_ff @(posedge pclk_i or posedge preset_i) begin
    if (preset_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wr_q      <= 1'b0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      for (int i = 0; i < 6; i++) regs_q[i] <= '0;
`ifdef APB_SLAVE_WRCNT_EN
      wrcnt_q   <= '0;
`else
      r6_q      <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wr_q      <= wr_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      for (int i = 0; i < 6; i++) regs_q[i] <= regs_d[i];
`ifdef APB_SLAVE_WRCNT_EN
      wrcnt_q   <= wrcnt_d;
`else
      r6_q      <= r6_d;
`endif
    end
  end

  assign prdata_o  = prdata_q;
  assign pready_o  = pready_q;
  assign pslverr_o = pslverr_q;

endmodule

// File: tb/tb_apb_slave_regs.sv
// Directed bench for apb_slave_regs: a table of APB transfers plus hand-built abort/reset/sampling sequences.
module tb_apb_slave_regs;

  localparam int unsigned TB_WAIT = 2;
  localparam logic [31:0] ID      = 32'h4150_4253;
  localparam int          NV      = 19;

  logic        clk = 1'b0;
  logic        rst;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [31:0] prdata;
  logic        pready, pslverr;

  int n_checks = 0;
  int n_errors = 0;

  apb_slave_regs #(.WAIT_CYCLES(TB_WAIT), .ID_VALUE(ID)) dut (
    .pclk_i    (clk),
    .preset_i  (rst),
    .psel_i    (psel),
    .penable_i (penable),
    .pwrite_i  (pwrite),
    .paddr_i   (paddr),
    .pwdata_i  (pwdata),
    .prdata_o  (prdata),
    .pready_o  (pready),
    .pslverr_o (pslverr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Waits (bounded) for PREADY after PENABLE has been driven, then ends the transfer.
  task automatic finish_xfer(input string tag, output logic [31:0] rd, output logic er);
    int  waits;
    bit  done;
    waits = 0;
    done  = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(posedge clk); #1;
      if (pready) done = 1'b1;
      else        waits++;
    end
    check({tag, " pready seen"}, 32'(done), 32'd1);
    check({tag, " wait cycles"}, 32'(waits), 32'(TB_WAIT));
    rd      = prdata;
    er      = pslverr;
    psel    = 1'b0;
    penable = 1'b0;
    @(posedge clk); #1;
    check({tag, " pready single"}, 32'(pready), 32'd0);
  endtask

  task automatic apb_xfer(input string tag, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wd, output logic [31:0] rd, output logic er);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd;
    @(posedge clk); #1;
    penable = 1'b1;
    finish_xfer(tag, rd, er);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    bit          seen;

    vecs[0]  = '{1'b0, 32'h00, 32'h0,         32'h0,         1'b0};
    vecs[1]  = '{1'b1, 32'h08, 32'd123,       32'h0,         1'b0};
    vecs[2]  = '{1'b0, 32'h08, 32'h0,         32'd123,       1'b0};
    vecs[3]  = '{1'b0, 32'h1C, 32'h0,         ID,            1'b0};
    vecs[4]  = '{1'b1, 32'h1C, 32'd5,         ID,            1'b1};
    vecs[5]  = '{1'b0, 32'h1C, 32'h0,         ID,            1'b0};
    vecs[6]  = '{1'b0, 32'h20, 32'h0,         ID,            1'b1};
    vecs[7]  = '{1'b1, 32'h06, 32'hDEAD,      ID,            1'b1};
    vecs[8]  = '{1'b0, 32'h04, 32'h0,         32'h0,         1'b0};
    vecs[9]  = '{1'b1, 32'h14, 32'hA5A5_5A5A, 32'h0,         1'b0};
    vecs[10] = '{1'b1, 32'h10, 32'h1,         32'h0,         1'b0};
    vecs[11] = '{1'b0, 32'h14, 32'h0,         32'hA5A5_5A5A, 1'b0};
    vecs[12] = '{1'b0, 32'h10, 32'h0,         32'h1,         1'b0};
    vecs[13] = '{1'b1, 32'h20, 32'd7,         32'h1,         1'b1};
    vecs[14] = '{1'b0, 32'h00, 32'h0,         32'h0,         1'b0};
    vecs[15] = '{1'b0, 32'h03, 32'h0,         32'h0,         1'b1};
`ifdef APB_SLAVE_WRCNT_EN
    vecs[16] = '{1'b1, 32'h18, 32'd42,        32'h0,         1'b1};
    vecs[17] = '{1'b0, 32'h18, 32'h0,         32'd3,         1'b0};
`else
    vecs[16] = '{1'b1, 32'h18, 32'd42,        32'h0,         1'b0};
    vecs[17] = '{1'b0, 32'h18, 32'h0,         32'd42,        1'b0};
`endif
    vecs[18] = '{1'b0, 32'h0C, 32'h0,         32'h0,         1'b0};

    rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset prdata", prdata, 32'h0);
    check("reset pready", 32'(pready), 32'd0);
    check("reset pslverr", 32'(pslverr), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      apb_xfer($sformatf("v%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, er);
      check($sformatf("v%0d prdata", i), rd, vecs[i].exp_rd);
      check($sformatf("v%0d pslverr", i), 32'(er), 32'(vecs[i].exp_err));
    end

    // Error flag holds through idle and clears when the next SETUP begins; then abort in SETUP.
    apb_xfer("err24", 1'b0, 32'h24, 32'h0, rd, er);
    check("err24 pslverr", 32'(er), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("pslverr hold idle", 32'(pslverr), 32'd1);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0C; pwdata = 32'h55;
    @(posedge clk); #1;
    check("pslverr clr setup", 32'(pslverr), 32'd0);
    psel = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (pready) seen = 1'b1;
    end
    check("setup abort no pready", 32'(seen), 32'd0);

    // Address/data/direction changes after the ACCESS edge must be ignored.
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0C; pwdata = 32'h11;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    paddr = 32'h10; pwdata = 32'h99; pwrite = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk); #1;
      if (pready) seen = 1'b1;
    end
    check("sample pready seen", 32'(seen), 32'd1);
    check("sample pslverr", 32'(pslverr), 32'd0);
    psel = 1'b0; penable = 1'b0;
    apb_xfer("rd0c", 1'b0, 32'h0C, 32'h0, rd, er);
    check("rd0c prdata", rd, 32'h11);
    apb_xfer("rd10", 1'b0, 32'h10, 32'h0, rd, er);
    check("rd10 prdata", rd, 32'h1);

    // PSEL dropped mid-ACCESS: no completion, no write.
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h04; pwdata = 32'd77;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (pready) seen = 1'b1;
    end
    check("psel drop no pready", 32'(seen), 32'd0);
    apb_xfer("rd04", 1'b0, 32'h04, 32'h0, rd, er);
    check("rd04 prdata", rd, 32'h0);
    check("rd04 pslverr", 32'(er), 32'd0);

    // Reset mid-ACCESS of a write: outputs clear at once, nothing committed.
    apb_xfer("rd08", 1'b0, 32'h08, 32'h0, rd, er);
    check("rd08 prdata", rd, 32'd123);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h00; pwdata = 32'd9;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("midrst prdata", prdata, 32'h0);
    check("midrst pready", 32'(pready), 32'd0);
    check("midrst pslverr", 32'(pslverr), 32'd0);
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    rst = 1'b0;
    apb_xfer("rd00", 1'b0, 32'h00, 32'h0, rd, er);
    check("rd00 prdata", rd, 32'h0);
    apb_xfer("rd08b", 1'b0, 32'h08, 32'h0, rd, er);
    check("rd08b prdata", rd, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
